// File: rtl/key_debounce_pkg.sv
// Shared definitions for the key input-conditioning blocks.
// Exports the debounce state encoding and the default qualification length.
package key_debounce_pkg;

  // 20 ms at 50 MHz.
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'b00,
    WAIT_HIGH = 2'b01,
    WAIT_LOW  = 2'b10,
    IDLE_HIGH = 2'b11
  } db_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer that brings one asynchronous bit into the clk domain.
// The synchronous reset clears both flops to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;
  logic s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;

endmodule

// File: rtl/key_debounce.sv
// Debounces a raw key level into key_clean and produces rise/fall pulses and a press count.
// A new level is accepted after DEBOUNCE_CYCLES+1 consecutive matching synchronized samples.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = 20,
  parameter int PRESS_W         = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_in,
  output logic               key_clean,
  output logic               key_rise,
  output logic               key_fall,
  output logic [PRESS_W-1:0] press_cnt,
  output logic               busy
);

  localparam longint CNT_LIMIT = longint'(1) << CNT_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (longint'(DEBOUNCE_CYCLES) < 2 || longint'(DEBOUNCE_CYCLES) >= CNT_LIMIT) begin : g_bad_cycles
    $error("key_debounce: DEBOUNCE_CYCLES must lie in 2 .. 2**CNT_W-1");
  end

  logic key_sync;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (key_in),
    .q   (key_sync)
  );

  // state_q is the observable FSM state for checkers.
  db_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               clean_q, clean_d;
  logic               rise_q, rise_d;
  logic               fall_q, fall_d;
  logic [PRESS_W-1:0] press_q, press_d;
  logic               busy_q, busy_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      press_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      press_q <= press_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    press_d = press_q;
    case (state_q)
      IDLE_LOW: begin
        if (key_sync) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!key_sync) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HIGH;
          clean_d = 1'b1;
          rise_d  = 1'b1;
          press_d = press_q + PRESS_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      IDLE_HIGH: begin
        if (!key_sync) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (key_sync) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LOW;
          clean_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
  end

  assign key_clean = clean_q;
  assign key_rise  = rise_q;
  assign key_fall  = fall_q;
  assign press_cnt = press_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed scenarios plus random key levels, checked every cycle
// against a run-length model of the debounce rule.
module tb_key_debounce;

  localparam int D  = 4;
  localparam int PW = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_in = 1'b0;
  always #5 clk = ~clk;

  logic          key_clean, key_rise, key_fall, busy;
  logic [PW-1:0] press_cnt;

  key_debounce #(.DEBOUNCE_CYCLES(D), .CNT_W(20), .PRESS_W(PW)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .key_clean (key_clean),
    .key_rise  (key_rise),
    .key_fall  (key_fall),
    .press_cnt (press_cnt),
    .busy      (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: key_sync is key_in delayed two edges; a level is accepted once D+1
  // consecutive synchronized samples disagree with the current clean level.
  logic          dly[2];
  logic          ks;
  int            run;
  logic          m_clean, m_rise, m_fall, m_busy;
  logic [PW-1:0] m_press;

  always @(posedge clk) begin
    if (rst) begin
      dly[0] = 1'b0; dly[1] = 1'b0;
      run = 0;
      m_clean = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_busy = 1'b0;
      m_press = '0;
    end else begin
      ks = dly[1];
      dly[1] = dly[0];
      dly[0] = key_in;
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (ks != m_clean) begin
        run = run + 1;
        if (run == D + 1) begin
          m_clean = ks;
          run = 0;
          if (ks) begin
            m_rise = 1'b1;
            m_press = m_press + 1'b1;
          end else begin
            m_fall = 1'b1;
          end
        end
      end else begin
        run = 0;
      end
      m_busy = (run != 0);
    end
  end

  // compare process
  bit checking = 1'b0;
  int rise_seen = 0;
  int fall_seen = 0;

  always @(negedge clk) begin
    if (checking) begin
      chk("key_clean", 32'(key_clean), 32'(m_clean));
      chk("key_rise",  32'(key_rise),  32'(m_rise));
      chk("key_fall",  32'(key_fall),  32'(m_fall));
      chk("busy",      32'(busy),      32'(m_busy));
      chk("press_cnt", 32'(press_cnt), 32'(m_press));
      if (key_rise === 1'b1) rise_seen++;
      if (key_fall === 1'b1) fall_seen++;
    end
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n, input logic k);
    rst = 1'b1;
    key_in = k;
    cyc(n);
    rst = 1'b0;
  endtask

  int r0, f0;

  initial begin
    // Reset held 3 cycles with the key already high.
    rst = 1'b1;
    key_in = 1'b1;
    @(negedge clk);
    checking = 1'b1;
    cyc(2);
    chk("rst_clean", 32'(key_clean), 32'd0);
    chk("rst_press", 32'(press_cnt), 32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    rst = 1'b0;
    cyc(6);
    chk("post_rst_clean_early", 32'(key_clean), 32'd0);
    cyc(1);
    chk("post_rst_clean", 32'(key_clean), 32'd1);
    chk("post_rst_rise",  32'(key_rise),  32'd1);
    chk("post_rst_press", 32'(press_cnt), 32'd1);
    cyc(1);
    chk("post_rst_rise_1cyc", 32'(key_rise), 32'd0);

    // Clean press with busy window.
    key_in = 1'b0;
    cyc(12);
    r0 = rise_seen;
    key_in = 1'b1;
    cyc(2);
    chk("press_busy_pre", 32'(busy), 32'd0);
    cyc(1);
    chk("press_busy_k2", 32'(busy), 32'd1);
    cyc(3);
    chk("press_busy_k5", 32'(busy), 32'd1);
    chk("press_clean_k5", 32'(key_clean), 32'd0);
    cyc(1);
    chk("press_clean_k6", 32'(key_clean), 32'd1);
    chk("press_busy_k6",  32'(busy),      32'd0);
    chk("press_cnt2",     32'(press_cnt), 32'd2);
    cyc(13);
    chk("press_one_rise", 32'(rise_seen - r0), 32'd1);

    // Bounce rejection.
    key_in = 1'b0;
    cyc(12);
    r0 = rise_seen;
    for (int i = 0; i < 2; i++) begin
      key_in = 1'b1; cyc(2);
      key_in = 1'b0; cyc(2);
    end
    cyc(10);
    chk("bounce_clean", 32'(key_clean), 32'd0);
    chk("bounce_press", 32'(press_cnt), 32'd2);
    chk("bounce_busy",  32'(busy),      32'd0);
    chk("bounce_rises", 32'(rise_seen - r0), 32'd0);

    // Release with a one-cycle glitch.
    key_in = 1'b1;
    cyc(12);
    f0 = fall_seen;
    key_in = 1'b0; cyc(2);
    key_in = 1'b1; cyc(1);
    key_in = 1'b0;
    cyc(6);
    chk("release_clean_early", 32'(key_clean), 32'd1);
    cyc(1);
    chk("release_clean", 32'(key_clean), 32'd0);
    cyc(10);
    chk("release_falls", 32'(fall_seen - f0), 32'd1);
    chk("release_press", 32'(press_cnt), 32'd3);

    // press_cnt wrap over 256 presses.
    do_reset(2, 1'b0);
    r0 = rise_seen;
    for (int i = 0; i < 256; i++) begin
      key_in = 1'b1; cyc(8);
      key_in = 1'b0; cyc(8);
      if (i == 254) chk("wrap_255", 32'(press_cnt), 32'd255);
    end
    chk("wrap_0", 32'(press_cnt), 32'd0);
    chk("wrap_rises", 32'(rise_seen - r0), 32'd256);

    // Reset in the middle of a rising qualification, key kept high.
    r0 = rise_seen;
    key_in = 1'b1;
    cyc(4);
    rst = 1'b1;
    cyc(1);
    chk("midrst_clean", 32'(key_clean), 32'd0);
    chk("midrst_busy",  32'(busy),      32'd0);
    rst = 1'b0;
    cyc(5);
    chk("midrst_no_rise", 32'(rise_seen - r0), 32'd0);
    cyc(5);
    chk("midrst_requal_rise",  32'(rise_seen - r0), 32'd1);
    chk("midrst_requal_clean", 32'(key_clean), 32'd1);

    // Random key levels with occasional resets.
    for (int i = 0; i < 300; i++) begin
      key_in = 1'($urandom_range(0, 1));
      cyc($urandom_range(1, 9));
      if ($urandom_range(0, 49) == 0) do_reset($urandom_range(1, 2), 1'($urandom_range(0, 1)));
    end
    key_in = 1'b0;
    cyc(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
